// File: rtl/mouse_pos_tracker.sv
// PS/2 mouse receiver: deserialises frames, assembles 3-byte movement packets
// and integrates the deltas into a clamped absolute cursor position.
module mouse_pos_tracker #(
  parameter int H_RES   = 800,
  parameter int V_RES   = 600,
  parameter int TIMEOUT = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        left,
  output logic        right,
  output logic        pos_valid
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    r_clkSync;
  logic [1:0]    r_dataSync;
  logic          r_clkPrev;
  logic [1:0]    r_state;
  logic [3:0]    r_bitCnt;
  logic [8:0]    r_shift;
  logic [7:0]    r_byte;
  logic          r_byteOk;
  logic [1:0]    r_idx;
  logic [1:0]    r_btn;
  logic [1:0]    r_sign;
  logic [1:0]    r_ovf;
  logic [7:0]    r_b1;
  logic [TW-1:0] r_toCnt;
  logic [11:0]   r_x;
  logic [11:0]   r_y;
  logic          r_left;
  logic          r_right;
  logic          r_posValid;

  logic               w_fall;
  logic               w_data;
  logic               w_active;
  logic               w_timeout;
  logic               w_byteValid;
  logic               w_frameErr;
  logic               w_pktDone;
  logic signed [12:0] w_dx;
  logic signed [12:0] w_dy;
  logic signed [12:0] w_nx;
  logic signed [12:0] w_ny;
  logic [11:0]        w_cx;
  logic [11:0]        w_cy;

  // Pads idle high, so synchronizers reset to 1 to avoid a phantom edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clkSync  <= 2'b11;
      r_dataSync <= 2'b11;
      r_clkPrev  <= 1'b1;
    end else begin
      r_clkSync  <= {r_clkSync[0], ps2_clk};
      r_dataSync <= {r_dataSync[0], ps2_data};
      r_clkPrev  <= r_clkSync[1];
    end
  end

  assign w_fall = r_clkPrev & ~r_clkSync[1];
  assign w_data = r_dataSync[1];

  assign w_active  = (r_state != S_IDLE) || (r_idx != 2'd0);
  assign w_timeout = w_active && (r_toCnt == TW'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_toCnt <= '0;
    end else if (w_fall || !w_active) begin
      r_toCnt <= '0;
    end else if (r_toCnt != TW'(TIMEOUT)) begin
      r_toCnt <= r_toCnt + TW'(1);
    end
  end

  // Shift register ends with data bits in [7:0] and parity in [8].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_bitCnt <= 4'd0;
      r_shift  <= 9'd0;
      r_byte   <= 8'd0;
      r_byteOk <= 1'b0;
    end else if (w_timeout) begin
      r_state  <= S_IDLE;
      r_byteOk <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_byteOk <= 1'b0;
          if (w_fall && !w_data) begin
            r_state  <= S_SHIFT;
            r_bitCnt <= 4'd0;
          end
        end
        S_SHIFT: begin
          if (w_fall) begin
            if (r_bitCnt == 4'd9) begin
              r_state  <= S_DONE;
              r_byte   <= r_shift[7:0];
              r_byteOk <= w_data & (^r_shift);
            end else begin
              r_shift  <= {w_data, r_shift[8:1]};
              r_bitCnt <= r_bitCnt + 4'd1;
            end
          end
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          r_byteOk <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_byteValid = (r_state == S_DONE) && r_byteOk;
  assign w_frameErr  = (r_state == S_DONE) && !r_byteOk;
  assign w_pktDone   = w_byteValid && (r_idx == 2'd2) && !w_timeout;

  // Index 0 only accepts bytes with bit3 set, which realigns a broken stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= 2'd0;
      r_btn  <= 2'd0;
      r_sign <= 2'd0;
      r_ovf  <= 2'd0;
      r_b1   <= 8'd0;
    end else if (w_timeout || w_frameErr) begin
      r_idx <= 2'd0;
    end else if (w_byteValid) begin
      case (r_idx)
        2'd0: begin
          if (r_byte[3]) begin
            r_btn  <= r_byte[1:0];
            r_sign <= r_byte[5:4];
            r_ovf  <= r_byte[7:6];
            r_idx  <= 2'd1;
          end
        end
        2'd1: begin
          r_b1  <= r_byte;
          r_idx <= 2'd2;
        end
        default: r_idx <= 2'd0;
      endcase
    end
  end

  // Byte 2 is consumed straight from the receiver during its DONE cycle.
  always_comb begin
    w_dx = r_ovf[0] ? 13'sd0 : $signed({{4{r_sign[0]}}, r_sign[0], r_b1});
    w_dy = r_ovf[1] ? 13'sd0 : $signed({{4{r_sign[1]}}, r_sign[1], r_byte});
    w_nx = $signed({1'b0, r_x}) + w_dx;
    w_ny = $signed({1'b0, r_y}) - w_dy;
    w_cx = w_nx[11:0];
    w_cy = w_ny[11:0];
    if (w_nx < 0)
      w_cx = 12'd0;
    else if (w_nx > H_RES - 1)
      w_cx = 12'(H_RES - 1);
    if (w_ny < 0)
      w_cy = 12'd0;
    else if (w_ny > V_RES - 1)
      w_cy = 12'(V_RES - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x        <= 12'(H_RES / 2);
      r_y        <= 12'(V_RES / 2);
      r_left     <= 1'b0;
      r_right    <= 1'b0;
      r_posValid <= 1'b0;
    end else begin
      r_posValid <= w_pktDone;
      if (w_pktDone) begin
        r_x     <= w_cx;
        r_y     <= w_cy;
        r_left  <= r_btn[0];
        r_right <= r_btn[1];
      end
    end
  end

  assign x         = r_x;
  assign y         = r_y;
  assign left      = r_left;
  assign right     = r_right;
  assign pos_valid = r_posValid;

endmodule
